// File: rtl/gf2m_digit_serial_mult.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gf2m_digit_serial_mult
// Purpose  : Digit-serial GF(2^WIDTH) multiplier. Consumes DIGIT bits of b per
//            cycle, MSB digit first, then either reduces modulo
//            x^WIDTH + POLY (op_mode=0) or returns the upper WIDTH bits of the
//            raw carry-less product (op_mode=1). Valid/ready on both sides.
// Options  : define GFM_OP_COUNT_EN to add a 16-bit completed-transfer counter
//            on port op_count.
// Revision : 1.0 - initial release
// ============================================================================
module gf2m_digit_serial_mult #(
  parameter int               WIDTH = 8,
  parameter int               DIGIT = 2,
  parameter logic [WIDTH-1:0] POLY  = 8'h1B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef GFM_OP_COUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  // Number of digits, padded b width, accumulator and partial-product widths.
  localparam int N    = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int BW   = N * DIGIT;
  localparam int ACCW = 2 * WIDTH + DIGIT - 1;
  localparam int PPW  = WIDTH + DIGIT - 1;
  localparam int PW   = 2 * WIDTH - 1;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  // Full reduction polynomial (explicit x^WIDTH term) at product width.
  localparam logic [PW-1:0] POLY_FULL = PW'({1'b1, POLY});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RED  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [BW-1:0]     b_q, b_d;
  logic              mode_q, mode_d;

  logic [DIGIT-1:0]  digit;
  logic [PPW-1:0]    pp;
  logic [PW-1:0]     fold;
  logic [WIDTH-1:0]  red;
  logic              unused_acc_msbs;

  // The top DIGIT accumulator bits only ever hold zeros shifted out.
  assign unused_acc_msbs = ^acc_q[ACCW-1:ACCW-DIGIT];

  // Carry-less product of a with the current b digit.
  always_comb begin
    digit = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    pp    = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (digit[j]) pp = pp ^ (PPW'(a_q) << j);
    end
  end

  // Fold product bits 2W-2..W back into the field, highest bit first.
  always_comb begin
    fold = acc_q[PW-1:0];
    for (int i = PW - 1; i >= WIDTH; i--) begin
      if (fold[i]) fold = fold ^ (POLY_FULL << (i - WIDTH));
    end
    red = fold[WIDTH-1:0];
  end

  // Next-state and datapath update for the IDLE/MUL/RED/DONE sequence.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d              = a;
          b_d              = '0;
          b_d[WIDTH-1:0]   = b;
          mode_d           = op_mode;
          acc_d            = '0;
          cnt_d            = CW'(N - 1);
          state_d          = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = (acc_q << DIGIT) ^ ACCW'(pp);
        if (cnt_q == '0) state_d = S_RED;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RED: begin
        y_d         = mode_q ? acc_q[2*WIDTH-2:WIDTH-1] : red;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered ready: high only in cycles spent in IDLE, so never in the
    // cycle of an output transfer.
    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

`ifdef GFM_OP_COUNT_EN
  logic [15:0] op_count_q, op_count_d;

  // Count completed output transfers, wrapping at 16 bits.
  always_comb begin
    op_count_d = (out_valid_q && out_ready) ? op_count_q + 16'd1 : op_count_q;
  end

  // Transfer counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  // No transfer counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf2m_digit_serial_mult.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gf2m_digit_serial_mult
// Purpose  : Self-checking bench: directed vector table, back-pressure and
//            mid-operation reset sequences, and random sweeps over several
//            WIDTH/DIGIT/POLY configurations against a shift-and-add model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf2m_digit_serial_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp       = 0;
  int   n_bad       = 0;
  int   sweeps_done = 0;
  logic p_rst_n     = 1'b0;
  logic s_rst_n     = 1'b0;

  // Reference: mode 0 is bit-serial field multiply (xtime and add), mode 1 is
  // the full schoolbook carry-less product shifted down by w-1.
  function automatic logic [63:0] ref_mul(input logic [63:0] ra, input logic [63:0] rb,
                                          input logic [63:0] poly, input int w,
                                          input logic mode);
    logic [127:0] prod;
    logic [63:0]  r;
    logic [63:0]  mask;
    mask = (64'd1 << w) - 64'd1;
    if (mode) begin
      prod = '0;
      for (int i = 0; i < w; i++) if (rb[i]) prod = prod ^ (128'(ra) << i);
      return 64'(prod >> (w - 1)) & mask;
    end
    r = '0;
    for (int i = w - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[w]) r = r ^ ((64'd1 << w) | poly);
      if (rb[i]) r = r ^ ra;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Primary DUT: default configuration WIDTH=8, DIGIT=2, POLY=0x1B
  // --------------------------------------------------------------------------
  logic       p_in_valid, p_in_ready, p_mode, p_out_valid, p_out_ready;
  logic [7:0] p_a, p_b, p_y;
`ifdef GFM_OP_COUNT_EN
  logic [15:0] p_cnt;
`endif

  gf2m_digit_serial_mult #(.WIDTH(8), .DIGIT(2), .POLY(8'h1B)) u_dut (
    .clk       (clk),
    .rst_n     (p_rst_n),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .a         (p_a),
    .b         (p_b),
    .op_mode   (p_mode),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .y         (p_y)
`ifdef GFM_OP_COUNT_EN
    ,
    .op_count  (p_cnt)
`endif
  );

  task automatic p_wait_ready(input string name);
    int g = 0;
    while (!p_in_ready && g < 50) begin @(posedge clk); #1; g++; end
    check({name, " in_ready"}, 64'(p_in_ready), 64'd1);
  endtask

  // One full operation on the primary DUT with out_ready held high.
  task automatic p_run(input logic [7:0] va, input logic [7:0] vb, input logic vm,
                       input logic [7:0] exp, input string name);
    int lat;
    logic ir_bad;
    p_wait_ready(name);
    p_a = va; p_b = vb; p_mode = vm; p_in_valid = 1'b1; p_out_ready = 1'b1;
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    p_a = 8'($urandom); p_b = 8'($urandom); p_mode = ~vm;
    lat = 0; ir_bad = 1'b0;
    while (!p_out_valid && lat < 50) begin
      if (p_in_ready) ir_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (p_in_ready) ir_bad = 1'b1;
    check({name, " latency"}, 64'(lat), 64'd5);
    check({name, " y"}, 64'(p_y), 64'(exp));
    check({name, " in_ready busy"}, 64'(ir_bad), 64'd0);
    @(posedge clk); #1;
    check({name, " out_valid drop"}, 64'(p_out_valid), 64'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int   g;
    logic bad;
    logic [7:0] ra, rb;
    logic rm;

    tbl[0] = '{8'h57, 8'h83, 1'b0, 8'hC1};
    tbl[1] = '{8'h80, 8'h02, 1'b0, 8'h1B};
    tbl[2] = '{8'h57, 8'h13, 1'b0, 8'hFE};
    tbl[3] = '{8'hA5, 8'h01, 1'b0, 8'hA5};
    tbl[4] = '{8'h00, 8'hFF, 1'b0, 8'h00};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hAA};
    tbl[6] = '{8'h80, 8'h80, 1'b1, 8'h80};

    p_in_valid = 1'b0; p_a = '0; p_b = '0; p_mode = 1'b0; p_out_ready = 1'b1;

    // Reset state
    #12;
    check("reset in_ready", 64'(p_in_ready), 64'd0);
    check("reset out_valid", 64'(p_out_valid), 64'd0);
    check("reset y", 64'(p_y), 64'd0);
    #1;
    p_rst_n = 1'b1;
    s_rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after release", 64'(p_in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      p_run(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Back-pressure: out_ready low for 10 cycles, in_valid pushed meanwhile
    p_wait_ready("bp");
    p_a = 8'h57; p_b = 8'h83; p_mode = 1'b0; p_in_valid = 1'b1; p_out_ready = 1'b0;
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    g = 0;
    while (!p_out_valid && g < 50) begin @(posedge clk); #1; g++; end
    check("bp out_valid", 64'(p_out_valid), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      p_in_valid = 1'b1; p_a = 8'($urandom); p_b = 8'($urandom);
      @(posedge clk); #1;
      if (p_y !== 8'hC1 || p_out_valid !== 1'b1 || p_in_ready !== 1'b0) bad = 1'b1;
    end
    check("bp stable", 64'(bad), 64'd0);
    check("bp y", 64'(p_y), 64'hC1);
    p_in_valid = 1'b0; p_out_ready = 1'b1;
    check("bp no bypass ready", 64'(p_in_ready), 64'd0);
    @(posedge clk); #1;
    check("bp transfer out_valid", 64'(p_out_valid), 64'd0);
    check("bp ready after transfer", 64'(p_in_ready), 64'd1);

    // Asynchronous reset in the second MUL cycle
    p_a = 8'h57; p_b = 8'h83; p_mode = 1'b0; p_in_valid = 1'b1;
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    @(posedge clk); #1;
    p_rst_n = 1'b0;
    #1;
    check("rst out_valid", 64'(p_out_valid), 64'd0);
    check("rst y", 64'(p_y), 64'd0);
    check("rst in_ready", 64'(p_in_ready), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (p_out_valid !== 1'b0 || p_y !== 8'h00 || p_in_ready !== 1'b0) bad = 1'b1;
    end
    check("rst held", 64'(bad), 64'd0);
    p_rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst release in_ready", 64'(p_in_ready), 64'd1);
    check("rst release out_valid", 64'(p_out_valid), 64'd0);
    p_run(8'h57, 8'h83, 1'b0, 8'hC1, "post_reset");

    // Random vectors on the primary configuration
    for (int t = 0; t < 1000; t++) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
      p_run(ra, rb, rm, 8'(ref_mul(64'(ra), 64'(rb), 64'h1B, 8, rm)), "rand_w8d2");
    end

    // Wait for the parameter sweeps
    g = 0;
    while (sweeps_done < 4 && g < 40000) begin @(posedge clk); g++; end
    check("sweeps finished", 64'(sweeps_done), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // --------------------------------------------------------------------------
  // Parameter sweep instances: DIGIT=1,3,8 at WIDTH=8; WIDTH=5 POLY=0x05
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < 4; k++) begin : g_sweep
    localparam int W = (k == 3) ? 5 : 8;
    localparam int D = (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 8 : 2;
    localparam logic [W-1:0] P = (k == 3) ? W'(5'h05) : W'(8'h1B);
    localparam int N = (W + D - 1) / D;

    logic         iv, ir, md, ov, ordy;
    logic [W-1:0] sa, sb, sy;
`ifdef GFM_OP_COUNT_EN
    logic [15:0]  scnt;
`endif

    gf2m_digit_serial_mult #(.WIDTH(W), .DIGIT(D), .POLY(P)) u_dut (
      .clk       (clk),
      .rst_n     (s_rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (sa),
      .b         (sb),
      .op_mode   (md),
      .out_valid (ov),
      .out_ready (ordy),
      .y         (sy)
`ifdef GFM_OP_COUNT_EN
      ,
      .op_count  (scnt)
`endif
    );

    initial begin
      logic [W-1:0] ra, rb;
      logic         rm;
      int           g, lat;
      logic [63:0]  e;
      iv = 1'b0; md = 1'b0; sa = '0; sb = '0; ordy = 1'b1;
      @(posedge s_rst_n);
      @(posedge clk); #1;
      for (int t = 0; t < 1000; t++) begin
        g = 0;
        while (!ir && g < 50) begin @(posedge clk); #1; g++; end
        check($sformatf("sweep%0d in_ready", k), 64'(ir), 64'd1);
        ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
        e  = ref_mul(64'(ra), 64'(rb), 64'(P), W, rm);
        sa = ra; sb = rb; md = rm; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0; sa = W'($urandom); sb = W'($urandom); md = ~rm;
        lat = 0;
        while (!ov && lat < 50) begin @(posedge clk); #1; lat++; end
        check($sformatf("sweep%0d latency", k), 64'(lat), 64'(N + 1));
        if (sy !== W'(e)) begin
          $display("FAIL sweep%0d y a=%0h b=%0h mode=%0d: got %0h expected %0h",
                   k, ra, rb, rm, sy, e);
          n_bad++;
        end
        n_cmp++;
        @(posedge clk); #1;
      end
`ifdef GFM_OP_COUNT_EN
      check($sformatf("sweep%0d op_count", k), 64'(scnt), 64'd1000);
`endif
      sweeps_done++;
    end
  end

endmodule
`default_nettype wire

// File: doc/gf2m_digit_serial_mult.md
Name: gf2m_digit_serial_mult

Overview:
Parametrised, sequential successor to the team's fixed 8-bit combinational Karatsuba GF(2) multiplier netlists. It is a digit-serial GF(2^WIDTH) polynomial multiplier, processing DIGIT bits of b per cycle, MSB digit first. It has two result modes: full field product reduced modulo POLY, or the upper WIDTH bits of the raw carry-less product (the legacy 8-bit "upper half" function). Valid/ready handshakes on both input and output sides, for use in crypto/ECC datapaths.

Parameters:
WIDTH, 8, field degree m; operand and result width (2..64)
DIGIT, 2, b bits consumed per MUL cycle (1..WIDTH)
POLY, 8'h1B, low WIDTH bits of the irreducible polynomial; the x^WIDTH term is implicit

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand a
b  input  WIDTH  operand b
op_mode  input  1  0 = reduced a·b mod P; 1 = raw carry-less product bits [2·WIDTH-2 : WIDTH-1]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
y  output  WIDTH  result

Behaviour:
- Definitions: N = ceil(WIDTH/DIGIT). b is zero-extended at the MSB end to N·DIGIT bits. The accumulator acc is 2·WIDTH+DIGIT-1 bits wide; its valid product bits are [2·WIDTH-2:0].
- Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n is low and 1 in the first cycle after release; out_valid=0; y=0; acc=0; digit counter=0.
- State machine: IDLE -> MUL -> RED -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b (extended) and op_mode; clear acc; set cnt=N-1; go to MUL.
- MUL (N cycles):
  - Each cycle: acc <= (acc << DIGIT) XOR clmul(a, b_digit[cnt]).
  - clmul is a carry-less DIGIT×WIDTH product; b_digit[cnt] is bits [cnt·DIGIT+DIGIT-1 : cnt·DIGIT] of the extended b.
  - cnt decrements each cycle; when cnt==0, go to RED.
- RED (1 cycle):
  - op_mode=0: y <= acc[2W-2:0] mod P, computed as a combinational fold from bit 2W-2 down to bit W. For each set bit i, XOR ({1,POLY} << (i-W)).
  - op_mode=1: y <= acc[2W-2:W-1].
  - Set out_valid=1; go to DONE.
- DONE:
  - y and out_valid are held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid <= 0; go to IDLE.
  - in_ready is asserted in the cycle after this transfer, never in the same cycle (no bypass).
- in_ready=0 in MUL, RED and DONE. in_valid is ignored there; the upstream source must hold its operands.
- Latency: for an acceptance edge E0, out_valid rises after edge E(N+1). WIDTH=8, DIGIT=2 gives 5 cycles. Throughput is one operation per N+3 cycles minimum, with out_ready held high.
- op_mode, a and b are sampled only at acceptance. Changes mid-operation have no effect.
- DIGIT=WIDTH: N=1, so MUL lasts a single cycle.
- Reset asserted mid-operation: the operation is aborted immediately. No out_valid is produced for it.
- Arithmetic is pure GF(2): XOR only, no carries.

Optional Feature:
Macro GFM_OP_COUNT_EN.
- Defined: adds port op_count, output, 16 bits.
  - Increments on each out_valid&&out_ready transfer.
  - Wraps from 16'hFFFF to 0.
  - Reset to 0 asynchronously by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- AES field check (WIDTH=8, DIGIT=2, POLY=8'h1B, op_mode=0): a=0x57, b=0x83 -> y=0xC1. out_valid rises 5 cycles after acceptance; in_ready=0 throughout MUL/RED/DONE.
- Reduction boundary, op_mode=0:
  - a=0x80, b=0x02 -> y=0x1B.
  - a=0x57, b=0x13 -> y=0xFE.
  - a=0xA5, b=0x01 -> y=0xA5.
  - a=0x00, b=0xFF -> y=0x00.
- Legacy high-half mode, op_mode=1:
  - a=0xFF, b=0xFF -> y=0xAA (raw product 0x5555).
  - a=0x80, b=0x80 -> y=0x80.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. y and out_valid stay stable and in_valid is ignored. Raise out_ready: transfer completes, then in_ready=1 on the next cycle.
- Async reset mid-MUL: drop rst_n in cycle 2 of MUL.
  - During reset: out_valid=0, y=0, in_ready=0.
  - After release: in_ready=1; a new operation a=0x57, b=0x83 returns 0xC1.
- Parameter sweep (DIGIT=1, 3, 8 and WIDTH=8; WIDTH=5 with POLY=5'h05): 1000 random vectors per configuration against a reference model. Latency equals N+1 in every configuration; with GFM_OP_COUNT_EN defined, op_count=1000 (0x03E8) at the end.
